axis_width_upsizer: RTL and testbench

- AXI-Stream narrow-to-wide packer that sits directly upstream of the team's registered-output stream FIFO.
- Packs RATIO consecutive IN_WIDTH-bit beats into one (IN_WIDTH*RATIO)-bit word, so the FIFO stores one wide word per RATIO narrow beats.
- Supports early word termination by s_last_i or by an idle timeout; valid lanes of a short word are flagged by m_keep_o.
- All m_* outputs are registered; the only combinational path is s_ready_o from m_ready_i.

---
 rtl/axis_width_upsizer.sv | 114 +++++++++++
 tb/tb_axis_width_upsizer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_upsizer.sv
// AXI-Stream narrow-to-wide packer: folds RATIO input beats into one registered
// output word, closing early on s_last_i or an optional idle timeout.
module axis_width_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  parameter int TIMEOUT  = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [IN_WIDTH-1:0]       s_data_i,
  input  logic                      s_last_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  output logic [IN_WIDTH*RATIO-1:0] m_data_o,
  output logic [RATIO-1:0]          m_keep_o,
  output logic                      m_last_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic                      partial_o
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int LANE_W    = $clog2(RATIO);
  localparam int TMO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN    = (TIMEOUT > 0);

  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [RATIO-1:0]     keep_q, keep_d;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;
  logic [LANE_W-1:0]    lane_cnt, lane_d;
  logic [TMO_W-1:0]     tmo_cnt, tmo_d;
  logic                 in_hs, out_hs;

  // Handshake: a beat moves when s_valid_i & s_ready_o, a word moves when
  // m_valid_o & m_ready_i. Input is accepted whenever the output slot is
  // empty or is being drained in this same cycle.
  assign s_ready_o = !valid_q || m_ready_i;
  assign in_hs     = s_valid_i && s_ready_o;
  assign out_hs    = valid_q && m_ready_i;

  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign m_last_o  = last_q;
  assign m_valid_o = valid_q;
  assign partial_o = (lane_cnt != '0);

  // The output register doubles as the accumulator; lane 0 clears the word.
  always_comb begin
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    lane_d  = lane_cnt;
    tmo_d   = '0;
    if (out_hs) valid_d = 1'b0;
    if (in_hs) begin
      if (lane_cnt == '0) begin
        data_d = '0;
        keep_d = '0;
      end
      for (int i = 0; i < RATIO; i++) begin
        if (lane_cnt == LANE_W'(i)) begin
          data_d[i*IN_WIDTH +: IN_WIDTH] = s_data_i;
          keep_d[i]                      = 1'b1;
        end
      end
      if (lane_cnt == LANE_W'(RATIO - 1) || s_last_i) begin
        valid_d = 1'b1;
        last_d  = s_last_i;
        lane_d  = '0;
      end else begin
        lane_d = lane_cnt + LANE_W'(1);
      end
    end else if (TMO_EN && partial_o && !valid_q) begin
      if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
        valid_d = 1'b1;
        last_d  = 1'b0;
        lane_d  = '0;
      end else begin
        tmo_d = tmo_cnt + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      lane_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      data_q   <= data_d;
      keep_q   <= keep_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      lane_cnt <= lane_d;
      tmo_cnt  <= tmo_d;
    end
  end

  a_valid_has_keep: assert property (@(posedge clk) disable iff (!reset_n)
    m_valid_o |-> (|m_keep_o));

  a_keep_contiguous: assert property (@(posedge clk) disable iff (!reset_n)
    m_valid_o |-> ((m_keep_o & (m_keep_o + RATIO'(1))) == '0));

  a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable(m_data_o) &&
                                   $stable(m_keep_o) && $stable(m_last_o)));

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Bench for axis_width_upsizer: directed scenarios plus a randomized stream,
// with a word-level expected queue fed by the beat driver.
module tb_axis_width_upsizer;

  localparam int IN_WIDTH  = 8;
  localparam int RATIO     = 4;
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int W         = OUT_WIDTH + RATIO + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [IN_WIDTH-1:0]  s_data = '0;
  logic                 s_last = 1'b0, s_valid = 1'b0, s_ready;
  logic [OUT_WIDTH-1:0] m_data;
  logic [RATIO-1:0]     m_keep;
  logic                 m_last, m_valid, m_ready = 1'b1, partial;

  logic [IN_WIDTH-1:0]  t_s_data = '0;
  logic                 t_s_last = 1'b0, t_s_valid = 1'b0, t_s_ready;
  logic [OUT_WIDTH-1:0] t_m_data;
  logic [RATIO-1:0]     t_m_keep;
  logic                 t_m_last, t_m_valid, t_partial;

  axis_width_upsizer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO), .TIMEOUT(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_keep_o(m_keep), .m_last_o(m_last), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .partial_o(partial)
  );

  axis_width_upsizer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO), .TIMEOUT(5)) dut_tmo (
    .clk(clk), .reset_n(reset_n),
    .s_data_i(t_s_data), .s_last_i(t_s_last), .s_valid_i(t_s_valid), .s_ready_o(t_s_ready),
    .m_data_o(t_m_data), .m_keep_o(t_m_keep), .m_last_o(t_m_last), .m_valid_o(t_m_valid),
    .m_ready_i(1'b1), .partial_o(t_partial)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  logic [OUT_WIDTH-1:0] mdl_data = '0;
  logic [RATIO-1:0]     mdl_keep = '0;
  int mdl_cnt = 0;
  bit rnd_done = 1'b0;

  // Reference packer: expected words are queued as {last, keep, data}.
  task automatic model_beat(input logic [IN_WIDTH-1:0] d, input logic l);
    if (mdl_cnt == 0) begin
      mdl_data = '0;
      mdl_keep = '0;
    end
    mdl_data[mdl_cnt*IN_WIDTH +: IN_WIDTH] = d;
    mdl_keep[mdl_cnt] = 1'b1;
    if (mdl_cnt == RATIO - 1 || l) begin
      exp_q.push_back({l, mdl_keep, mdl_data});
      mdl_cnt = 0;
    end else begin
      mdl_cnt++;
    end
  endtask

  task automatic send_beat(input logic [IN_WIDTH-1:0] d, input logic l, output int waited);
    waited = 0;
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout s_ready stayed 0, beat %h not accepted", d);
        break;
      end
      @(posedge clk); #1;
    end
    if (waited <= 200) model_beat(d, l);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic t_beat(input logic [IN_WIDTH-1:0] d);
    t_s_data = d;
    t_s_valid = 1'b1;
    @(posedge clk); #1;
    t_s_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got last=%b keep=%h data=%h, expected no word", m_last, m_keep, m_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({m_last, m_keep, m_data} !== exp_w) begin
          errors++;
          $display("FAIL sb_word got %h expected %h", {m_last, m_keep, m_data}, exp_w);
        end
      end
    end
  end

  task automatic test_reset;
    checks++;
    if ({m_valid, m_keep, m_data, m_last, partial, s_ready} !== {1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_main got v=%b k=%h d=%h l=%b p=%b r=%b expected 0/0/0/0/0/1",
               m_valid, m_keep, m_data, m_last, partial, s_ready);
    end
    checks++;
    if ({t_m_valid, t_m_keep, t_partial, t_s_ready} !== {1'b0, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_tmo got v=%b k=%h p=%b r=%b expected 0/0/0/1", t_m_valid, t_m_keep, t_partial, t_s_ready);
    end
  endtask

  task automatic test_full_word;
    int w;
    logic [IN_WIDTH-1:0] bytes_a[4];
    bytes_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(bytes_a[i], 1'b0, w);
      checks++;
      if (w !== 0) begin
        errors++;
        $display("FAIL full_ready beat %0d waited %0d cycles, expected 0", i, w);
      end
      if (i == 2) begin
        checks++;
        if ({m_valid, partial} !== 2'b01) begin
          errors++;
          $display("FAIL full_early got valid=%b partial=%b expected 0/1", m_valid, partial);
        end
      end
    end
    checks++;
    if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b0, 4'hF, 32'h44332211}) begin
      errors++;
      $display("FAIL full_word got v=%b l=%b k=%h d=%h expected 1/0/f/44332211", m_valid, m_last, m_keep, m_data);
    end
    @(posedge clk); #1;
    checks++;
    if ({m_valid, partial} !== 2'b00) begin
      errors++;
      $display("FAIL full_after got valid=%b partial=%b expected 0/0", m_valid, partial);
    end
  endtask

  task automatic test_short_word;
    int w;
    send_beat(8'hA1, 1'b0, w);
    send_beat(8'hB2, 1'b1, w);
    checks++;
    if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b1, 4'h3, 32'h0000B2A1}) begin
      errors++;
      $display("FAIL short_word got v=%b l=%b k=%h d=%h expected 1/1/3/0000b2a1", m_valid, m_last, m_keep, m_data);
    end
    send_beat(8'hC3, 1'b0, w);
    checks++;
    if ({m_valid, partial, m_keep, m_data} !== {1'b0, 1'b1, 4'h1, 32'h000000C3}) begin
      errors++;
      $display("FAIL short_next got v=%b p=%b k=%h d=%h expected 0/1/1/000000c3", m_valid, partial, m_keep, m_data);
    end
    send_beat(8'hD4, 1'b1, w);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int w;
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(8'(i), 1'b0, w);
    s_data = 8'h55;
    s_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({s_ready, m_valid, m_last, m_keep, m_data} !== {1'b0, 1'b1, 1'b0, 4'hF, 32'h04030201}) begin
        errors++;
        $display("FAIL hold_cycle%0d got r=%b v=%b l=%b k=%h d=%h expected 0/1/0/f/04030201",
                 c, s_ready, m_valid, m_last, m_keep, m_data);
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got %b expected 1", s_ready);
    end else begin
      model_beat(8'h55, 1'b0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    checks++;
    if ({m_valid, partial, m_keep, m_data} !== {1'b0, 1'b1, 4'h1, 32'h00000055}) begin
      errors++;
      $display("FAIL release_lane0 got v=%b p=%b k=%h d=%h expected 0/1/1/00000055", m_valid, partial, m_keep, m_data);
    end
    send_beat(8'h66, 1'b1, w);
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int w;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send_beat(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0), w);
        end
        if (mdl_cnt != 0) send_beat(8'hEE, 1'b1, w);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain %0d words still expected, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout;
    t_beat(8'h7E);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (t_m_valid !== 1'b0) begin
        errors++;
        $display("FAIL tmo_early idle %0d got valid=%b expected 0", k, t_m_valid);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({t_m_valid, t_m_last, t_m_keep, t_m_data, t_partial} !== {1'b1, 1'b0, 4'h1, 32'h0000007E, 1'b0}) begin
      errors++;
      $display("FAIL tmo_flush got v=%b l=%b k=%h d=%h p=%b expected 1/0/1/0000007e/0",
               t_m_valid, t_m_last, t_m_keep, t_m_data, t_partial);
    end
    @(posedge clk); #1;
    // A beat on the would-fire cycle wins and restarts the idle count.
    t_beat(8'h10);
    repeat (4) begin
      @(posedge clk); #1;
    end
    t_beat(8'h20);
    checks++;
    if ({t_m_valid, t_partial} !== 2'b01) begin
      errors++;
      $display("FAIL tmo_priority got valid=%b partial=%b expected 0/1", t_m_valid, t_partial);
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (t_m_valid !== 1'b0) begin
        errors++;
        $display("FAIL tmo_restart idle %0d got valid=%b expected 0", k, t_m_valid);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({t_m_valid, t_m_last, t_m_keep, t_m_data} !== {1'b1, 1'b0, 4'h3, 32'h00002010}) begin
      errors++;
      $display("FAIL tmo_flush2 got v=%b l=%b k=%h d=%h expected 1/0/3/00002010", t_m_valid, t_m_last, t_m_keep, t_m_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_word;
    int w;
    m_ready = 1'b1;
    send_beat(8'h77, 1'b0, w);
    send_beat(8'h88, 1'b0, w);
    #3;
    reset_n = 1'b0;
    mdl_cnt = 0;
    #1;
    checks++;
    if ({m_valid, partial, m_keep, s_ready} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got v=%b p=%b k=%h r=%b expected 0/0/0/1", m_valid, partial, m_keep, s_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_beat(8'hA0 + 8'(i), 1'b0, w);
    checks++;
    if ({m_valid, m_keep, m_data} !== {1'b1, 4'hF, 32'hA3A2A1A0}) begin
      errors++;
      $display("FAIL reset_clean got v=%b k=%h d=%h expected 1/f/a3a2a1a0", m_valid, m_keep, m_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    test_reset;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_full_word;
    test_short_word;
    test_back_to_back;
    test_timeout;
    test_random;
    test_reset_mid_word;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue %0d words left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
